// File: rtl/addsub16_seq_arb.sv
// Two-requester round-robin front end for a 4-bit add/sub slice that is reused
// over four cycles to produce a 16-bit two's-complement sum/difference.
module addsub16_seq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_sub,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_sub,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_ovfl,
    output logic        rsp_cout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        sub_q, sub_d, id_q, id_d;
    logic        carry_q, carry_d, last_q, last_d;
    logic [1:0]  nib_q, nib_d;
    logic [15:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_ovfl_q, rsp_ovfl_d, rsp_cout_q, rsp_cout_d, rsp_id_q, rsp_id_d;

    logic        grant0, grant1;
    logic [3:0]  an, bn, s;
    logic        c1, c2, c3, c4;

    // Round robin: on a tie the requester that did not win last time goes.
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = rst_n & (state_q == IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == IDLE) & grant1;

    assign an = a_q[{nib_q, 2'b00} +: 4];
    assign bn = b_q[{nib_q, 2'b00} +: 4] ^ {4{sub_q}};

    assign s[0] = an[0] ^ bn[0] ^ carry_q;
    assign c1   = (an[0] & bn[0]) | (carry_q & (an[0] ^ bn[0]));
    assign s[1] = an[1] ^ bn[1] ^ c1;
    assign c2   = (an[1] & bn[1]) | (c1 & (an[1] ^ bn[1]));
    assign s[2] = an[2] ^ bn[2] ^ c2;
    assign c3   = (an[2] & bn[2]) | (c2 & (an[2] ^ bn[2]));
    assign s[3] = an[3] ^ bn[3] ^ c3;
    assign c4   = (an[3] & bn[3]) | (c3 & (an[3] ^ bn[3]));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        sub_d      = sub_q;
        id_d       = id_q;
        carry_d    = carry_q;
        last_d     = last_q;
        nib_d      = nib_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_ovfl_d = rsp_ovfl_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    sub_d   = grant1 ? req1_sub : req0_sub;
                    carry_d = grant1 ? req1_sub : req0_sub;
                    id_d    = grant1;
                    last_d  = grant1;
                    nib_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d[{nib_q, 2'b00} +: 4] = s;
                carry_d = c4;
                if (nib_q == 2'd3) begin
                    // Overflow is carry into bit 15 xor carry out of bit 15.
                    rsp_sum_d  = {s, res_q[11:0]};
                    rsp_cout_d = c4;
                    rsp_ovfl_d = c4 ^ c3;
                    rsp_id_d   = id_q;
                    state_d    = DONE;
                end else begin
                    nib_d = nib_q + 2'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            sub_q      <= 1'b0;
            id_q       <= 1'b0;
            carry_q    <= 1'b0;
            last_q     <= 1'b1;
            nib_q      <= 2'd0;
            rsp_sum_q  <= '0;
            rsp_ovfl_q <= 1'b0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            sub_q      <= sub_d;
            id_q       <= id_d;
            carry_q    <= carry_d;
            last_q     <= last_d;
            nib_q      <= nib_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_ovfl_q <= rsp_ovfl_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovfl  = rsp_ovfl_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_addsub16_seq_arb.sv
// Scoreboard bench for addsub16_seq_arb: arithmetic and arbitration are
// predicted from plain integer math and a cycle-level availability model.
module tb_addsub16_seq_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_sub = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0;
    logic        req1_valid = 1'b0, req1_sub = 1'b0;
    logic [15:0] req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovfl, rsp_cout, busy;
    logic [15:0] rsp_sum;

    addsub16_seq_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovfl(rsp_ovfl),
        .rsp_cout(rsp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        ovfl;
        logic        cout;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0;
    logic m_last = 1'b1;
    int   m_free = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input int c);
        exp_t e;
        int sa, sb_, r;
        sa = $signed(a);
        sb_ = $signed(b);
        r = sub ? sa - sb_ : sa + sb_;
        e.id   = id;
        e.sum  = r[15:0];
        e.ovfl = (r > 32767) || (r < -32768);
        e.cout = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        e.cyc  = c;
        return e;
    endfunction

    // Monitor: response checking, ready/busy prediction, expectation push on accept.
    always @(negedge clk) begin
        exp_t e;
        logic idle, er0, er1;
        if (rsp_valid) begin
            chk("rsp_pulse_width", {31'd0, prev_v}, 32'd0);
            if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rsp_latency", cyc, e.cyc);
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
                chk("rsp_ovfl", {31'd0, rsp_ovfl}, {31'd0, e.ovfl});
                chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            chk("rsp_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        prev_v = rsp_valid;
        if (!rst_n) begin
            sb.delete();
            m_last = 1'b1;
            m_free = 0;
        end else begin
            idle = (cyc >= m_free);
            er0 = idle && req0_valid && (!req1_valid || m_last);
            er1 = idle && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
            chk("busy", {31'd0, busy}, {31'd0, !idle});
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc + 5));
                m_last = 1'b0;
                m_free = cyc + 6;
            end else if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc + 5));
                m_last = 1'b1;
                m_free = cyc + 6;
            end
        end
    end

    // Present a request, hold it until accepted, then drop valid and scramble operands.
    task automatic issue(input bit r, input logic [15:0] a, input logic [15:0] b, input logic s);
        int w = 0;
        if (!r) begin req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1; end
        else    begin req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1; end
        do begin
            @(negedge clk);
            w++;
        end while (!(r ? req1_ready : req0_ready) && w < 200);
        if (w >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!r) begin req0_valid = 1'b0; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sub = 1'($urandom); end
        else    begin req1_valid = 1'b0; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sub = 1'($urandom); end
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_sum", {16'd0, rsp_sum}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_ovfl", {31'd0, rsp_ovfl}, 32'd0);
        chk("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        issue(0, 16'h7FFF, 16'h0001, 1'b0);
        issue(1, 16'h0003, 16'h0005, 1'b1);
        issue(1, 16'h8000, 16'h0001, 1'b1);
        issue(0, 16'hFFFF, 16'h0001, 1'b0);

        // Both requesters held valid: expect strict alternation.
        fork
            begin issue(0, 16'h1111, 16'h2222, 1'b0); issue(0, 16'hA000, 16'h6000, 1'b1); end
            begin issue(1, 16'h4000, 16'h4000, 1'b0); issue(1, 16'h0010, 16'h0020, 1'b1); end
        join

        // req0 raised during req1's CALC with operands that change before acceptance.
        repeat (8) @(posedge clk);
        #1;
        fork
            issue(1, 16'h1234, 16'h0FFF, 1'b1);
            begin
                @(posedge clk);
                #1;
                req0_valid = 1'b1; req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_sub = 1'b0;
                @(posedge clk);
                #1;
                issue(0, 16'h7000, 16'h1000, 1'b0);
            end
        join

        // Reset while nibble 2 is being computed; operation must be abandoned.
        repeat (8) @(posedge clk);
        #1;
        issue(0, 16'h5A5A, 16'h1234, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        fork
            issue(0, 16'h0F0F, 16'h00F1, 1'b0);
            issue(1, 16'h8001, 16'h7FFF, 1'b1);
        join

        // Randomized traffic from both requesters.
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                issue(0, rand_op(), rand_op(), 1'($urandom));
            end
            for (int j = 0; j < 20; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                issue(1, rand_op(), rand_op(), 1'($urandom));
            end
        join

        repeat (12) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub16_seq_arb.md
# addsub16_seq_arb

Sequencing controller and two-port arbiter for the team's 4-bit ripple add/sub slice. It performs 16-bit two's-complement add/subtract by running one 4-bit slice over four cycles, least-significant nibble first, and chaining the carry through a register. Two requesters share the slice through a valid/ready handshake with round-robin arbitration. The block sits between the requesting units and the arithmetic datapath.

## Interface
Parameters: none. Width is fixed at 16 bits, processed as 4 nibbles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_a  in  16  requester 0 operand A.
- req0_b  in  16  requester 0 operand B.
- req0_sub  in  1  requester 0 operation select: 1 = A−B, 0 = A+B.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_a, req1_b, req1_sub, req1_ready  same as above, for requester 1.
- rsp_valid  out  1  one-cycle pulse: result fields are valid.
- rsp_id  out  1  which requester the result belongs to.
- rsp_sum  out  16  16-bit result.
- rsp_ovfl  out  1  signed overflow.
- rsp_cout  out  1  carry out of bit 15.
- busy  out  1  high in CALC and DONE.

## Operation
- Internal slice: 4 full adders. Inputs are a nibble of A, a nibble of B XOR {4{sub}}, and a registered carry.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req0_ready/req1_ready = grant to that requester. Grant is combinational from the valids and last_grant.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester that is not last_grant.
  - On a grant, latch a, b, sub and id; set carry = sub, nib = 0, last_grant = id; go to CALC.
- CALC, each cycle:
  - Compute the nibble selected by nib, write it into result[4*nib+3:4*nib], and register the slice carry out.
  - At nib = 3, also capture cout and ovfl, then go to DONE. Otherwise nib = nib + 1.
- DONE: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Overflow rule:
  - ovfl = 1 iff a[15] == (b[15]^sub) and sum[15] != a[15].
  - Equivalently, carry into bit 15 XOR carry out of bit 15.
- rsp_cout is the raw carry out. For subtract, 1 means no borrow.
- rsp_sum, rsp_ovfl, rsp_cout and rsp_id update only on entry to DONE and hold between results.
- Requesters must hold valid and operands stable until ready. Operands are ignored after acceptance.
- Readies are 0 outside IDLE, so a valid raised during CALC/DONE waits.

## Timing
- Acceptance at edge T (valid & ready high in the preceding cycle).
- Nibbles 0–3 are written at edges T+1 through T+4.
- rsp_valid is high from edge T+4 to edge T+5.
- IDLE is re-entered at T+5, so the next acceptance is at the earliest at edge T+6. Throughput is one operation per 6 cycles.
- Reset (rst_n = 0 sampled at an edge):
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie), carry = 0, nib = 0.
  - All outputs 0: rsp_valid, rsp_id, rsp_sum, rsp_ovfl, rsp_cout, busy, and both readies.
- Reset mid-operation: the operation is abandoned with no rsp_valid. Readies may assert in the first cycle after rst_n returns high.
- Readies are gated by rst_n: both are 0 while rst_n = 0.
- A requester dropping valid while in IDLE (without acceptance) is legal. Nothing is latched.

## Test plan
- req0: 0x7FFF + 0x0001, sub = 0 → at T+4: rsp_sum = 0x8000, ovfl = 1, cout = 0, id = 0. rsp_valid is high for exactly 1 cycle.
- req1: 0x0003 − 0x0005 → rsp_sum = 0xFFFE, ovfl = 0, cout = 0, id = 1. Also check 0x8000 − 0x0001 → 0x7FFF, ovfl = 1, cout = 1.
- req0: 0xFFFF + 0x0001 → rsp_sum = 0x0000, cout = 1, ovfl = 0. This checks carry propagation across all four nibbles.
- Both valid, held continuously after reset:
  - Grant order is 0, 1, 0, 1 with accept edges 6 cycles apart.
  - rsp_id alternates, and each result matches its own operands.
- Assert rst_n = 0 for one edge while nib = 2 → no rsp_valid, all outputs 0, busy = 0. A new request is accepted on the first edge after release with correct results. The first tie after reset goes to requester 0.
- req0 valid raised during CALC of a req1 operation → req0_ready stays 0 until IDLE. req0 is accepted at edge T+6, and its operands are unaffected by changes made before that acceptance.
